// File: rtl/stream_cmd_arbiter_pkg.sv
// stream_cmd_arbiter_pkg: shared FSM encoding and width helpers for the command arbiter
package stream_cmd_arbiter_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_e;
  function automatic int tid_w(input int max_accs);
    return max_accs > 1 ? $clog2(max_accs) : 1;
  endfunction
  function automatic int src_w(input int num_in);
    return num_in > 1 ? $clog2(num_in) : 1;
  endfunction
endpackage

// File: rtl/stream_cmd_arbiter_if.sv
// stream_cmd_arbiter_if: requester streams in, merged stream out; master is the arbiter side
interface stream_cmd_arbiter_if #(
  parameter int NUM_IN   = 3,
  parameter int MAX_ACCS = 16,
  parameter int DATA_W   = 64
);
  import stream_cmd_arbiter_pkg::*;
  localparam int TID_W = tid_w(MAX_ACCS);
  localparam int SRC_W = src_w(NUM_IN);
  logic [NUM_IN-1:0]        in_tvalid;
  logic [NUM_IN-1:0]        in_tready;
  logic [NUM_IN*TID_W-1:0]  in_tid;
  logic [NUM_IN*DATA_W-1:0] in_tdata;
  logic [NUM_IN-1:0]        in_tlast;
  logic                     out_tvalid;
  logic                     out_tready;
  logic [TID_W-1:0]         out_tid;
  logic [DATA_W-1:0]        out_tdata;
  logic                     out_tlast;
  logic [SRC_W-1:0]         out_tsrc;
  modport master (
    input  in_tvalid, in_tid, in_tdata, in_tlast, out_tready,
    output in_tready, out_tvalid, out_tid, out_tdata, out_tlast, out_tsrc
  );
  modport slave (
    output in_tvalid, in_tid, in_tdata, in_tlast, out_tready,
    input  in_tready, out_tvalid, out_tid, out_tdata, out_tlast, out_tsrc
  );
endinterface

// File: rtl/stream_cmd_arbiter_rr_pointer_sel.sv
// stream_cmd_arbiter_rr_pointer_sel: first valid port at or after ptr, searched cyclically
module stream_cmd_arbiter_rr_pointer_sel #(
  parameter int NUM_IN = 3,
  parameter int SRC_W  = 2
) (
  input  logic [NUM_IN-1:0] valid,
  input  logic [SRC_W-1:0]  ptr,
  output logic [SRC_W-1:0]  sel,
  output logic              any
);
  assign any = |valid;
  always_comb begin
    sel = ptr;
    // scanning farthest-first lets the nearest valid port win by overwriting
    for (int i = NUM_IN - 1; i >= 0; i--)
      if (valid[(int'(ptr) + i) % NUM_IN]) sel = SRC_W'((int'(ptr) + i) % NUM_IN);
  end
endmodule

// File: rtl/stream_cmd_arbiter.sv
// stream_cmd_arbiter: packet-locked round-robin merge of NUM_IN AXI-Stream requesters
module stream_cmd_arbiter
  import stream_cmd_arbiter_pkg::*;
#(
  parameter int NUM_IN   = 3,
  parameter int MAX_ACCS = 16,
  parameter int DATA_W   = 64
) (
  input  logic                clk,
  input  logic                rst,
  stream_cmd_arbiter_if.master s,
  output logic                busy
);
  localparam int TID_W = tid_w(MAX_ACCS);
  localparam int SRC_W = src_w(NUM_IN);
  arb_state_e        state_q, state_d;
  logic [SRC_W-1:0]  grant_q, grant_d, ptr_q, ptr_d, sel;
  logic              any_valid, accept;
  logic [NUM_IN-1:0] in_tready;
  logic              out_tvalid_q, out_tvalid_d, out_tlast_q, out_tlast_d;
  logic [TID_W-1:0]  out_tid_q, out_tid_d;
  logic [DATA_W-1:0] out_tdata_q, out_tdata_d;
  logic [SRC_W-1:0]  out_tsrc_q, out_tsrc_d;

  stream_cmd_arbiter_rr_pointer_sel #(.NUM_IN(NUM_IN), .SRC_W(SRC_W)) u_sel (
    .valid(s.in_tvalid),
    .ptr  (ptr_q),
    .sel  (sel),
    .any  (any_valid)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    in_tready = '0;
    if (state_q == BUSY && !rst) in_tready[grant_q] = !out_tvalid_q || s.out_tready;
    accept       = s.in_tvalid[grant_q] && in_tready[grant_q];
    out_tvalid_d = accept || (out_tvalid_q && !s.out_tready);
    out_tid_d    = accept ? s.in_tid[int'(grant_q)*TID_W +: TID_W] : out_tid_q;
    out_tdata_d  = accept ? s.in_tdata[int'(grant_q)*DATA_W +: DATA_W] : out_tdata_q;
    out_tlast_d  = accept ? s.in_tlast[grant_q] : out_tlast_q;
    out_tsrc_d   = accept ? grant_q : out_tsrc_q;
    if (state_q == IDLE && any_valid) begin
      grant_d = sel;
      state_d = BUSY;
    end
    if (accept && s.in_tlast[grant_q]) begin
      state_d = IDLE;
      ptr_d   = (grant_q == SRC_W'(NUM_IN - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ptr_q        <= '0;
      out_tvalid_q <= 1'b0;
      out_tid_q    <= '0;
      out_tdata_q  <= '0;
      out_tlast_q  <= 1'b0;
      out_tsrc_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      out_tvalid_q <= out_tvalid_d;
      out_tid_q    <= out_tid_d;
      out_tdata_q  <= out_tdata_d;
      out_tlast_q  <= out_tlast_d;
      out_tsrc_q   <= out_tsrc_d;
    end
  end

  assign s.in_tready  = in_tready;
  assign s.out_tvalid = out_tvalid_q;
  assign s.out_tid    = out_tid_q;
  assign s.out_tdata  = out_tdata_q;
  assign s.out_tlast  = out_tlast_q;
  assign s.out_tsrc   = out_tsrc_q;
  assign busy         = state_q == BUSY;
endmodule

// File: tb/tb_stream_cmd_arbiter.sv
// tb_stream_cmd_arbiter: directed packets per port, expected beats queued in grant order
module tb_stream_cmd_arbiter;
  localparam int NUM_IN = 3, MAX_ACCS = 16, DATA_W = 64, TID_W = 4, SRC_W = 2;
  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [TID_W-1:0]  tid;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  stream_cmd_arbiter_if #(.NUM_IN(NUM_IN), .MAX_ACCS(MAX_ACCS), .DATA_W(DATA_W)) bus ();
  stream_cmd_arbiter #(.NUM_IN(NUM_IN), .MAX_ACCS(MAX_ACCS), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus.master),
    .busy(busy)
  );
  always #5 clk = ~clk;

  beat_t             pq[NUM_IN][$];
  beat_t             exp_q[$];
  beat_t             mon_got, mon_exp;
  logic [NUM_IN-1:0] hold = '0;
  logic [NUM_IN-1:0] acc = '0;
  int                acc_cnt[NUM_IN] = '{0, 0, 0};
  int                checks = 0;
  int                errors = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic pkt(input int p, input logic [TID_W-1:0] tid, input int n,
                     input logic [DATA_W-1:0] base, input int nexp = -1);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.src  = SRC_W'(p);
      b.tid  = tid;
      b.data = base + DATA_W'(i);
      b.last = (i == n - 1);
      pq[p].push_back(b);
      if (nexp < 0 || i < nexp) exp_q.push_back(b);
    end
  endtask

  // one clock: retire last cycle's accepted beats, present heads, sample handshakes
  task automatic step(input logic otr = 1'b1, input logic r = 1'b0);
    beat_t h;
    @(negedge clk);
    rst = r;
    bus.out_tready = otr;
    for (int p = 0; p < NUM_IN; p++) begin
      if (acc[p]) begin
        pq[p].delete(0);
        acc_cnt[p]++;
      end
      h = pq[p].size() > 0 ? pq[p][0] : '0;
      bus.in_tvalid[p] = pq[p].size() > 0 && !hold[p];
      bus.in_tid[p*TID_W +: TID_W] = h.tid;
      bus.in_tdata[p*DATA_W +: DATA_W] = h.data;
      bus.in_tlast[p] = h.last;
    end
    #1;
    acc = bus.in_tvalid & bus.in_tready;
  endtask

  task automatic wait_acc(input int p, input int n);
    int base = acc_cnt[p];
    int k = 0;
    while (acc_cnt[p] + int'(acc[p]) < base + n && k < 100) begin
      step();
      k++;
    end
    check("wait_acc_timeout", k < 100, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || busy || bus.out_tvalid ||
            pq[0].size() > 0 || pq[1].size() > 0 || pq[2].size() > 0) && n < 200) begin
      step();
      n++;
    end
    check("drain_timeout", n < 200, 1'b1);
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && bus.out_tvalid && bus.out_tready) begin
      mon_got = {bus.out_tsrc, bus.out_tid, bus.out_tdata, bus.out_tlast};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat", mon_got, mon_exp);
      end
    end
  end

  initial begin
    bus.in_tvalid = '0;
    bus.in_tid = '0;
    bus.in_tdata = '0;
    bus.in_tlast = '0;
    bus.out_tready = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("rst_out_tvalid", bus.out_tvalid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_tready", bus.in_tready, 3'b000);
    check("rst_out_fields", {bus.out_tdata, bus.out_tid, bus.out_tlast, bus.out_tsrc}, '0);

    // single 3-beat packet on port 1, two-edge latency to first output beat
    pkt(1, 4'd5, 3, 64'hA0);
    step();
    check("lat_c1_out_tvalid", bus.out_tvalid, 1'b0);
    check("lat_c1_in_tready", bus.in_tready, 3'b000);
    step();
    check("lat_c2_out_tvalid", bus.out_tvalid, 1'b0);
    check("lat_c2_busy", busy, 1'b1);
    check("lat_c2_in_tready", bus.in_tready, 3'b010);
    step();
    check("lat_c3_out_tvalid", bus.out_tvalid, 1'b1);
    drain();

    // all ports contending from pointer 0: grant order 0,1,2,0
    step(1'b1, 1'b1);
    pkt(0, 4'd1, 2, 64'h10);
    pkt(1, 4'd2, 2, 64'h20);
    pkt(2, 4'd3, 2, 64'h30);
    pkt(0, 4'd4, 2, 64'h40);
    drain();

    // backpressure holds the output register and blocks the granted port
    pkt(0, 4'd3, 3, 64'hC0);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      check("stall_out_tvalid", bus.out_tvalid, 1'b1);
      check("stall_out_tdata", bus.out_tdata, 64'hC0);
      check("stall_in_tready0", bus.in_tready[0], 1'b0);
    end
    drain();

    // pointer walks 1 -> 2 -> wraps to 0 -> 1, with 1-beat packets
    pkt(1, 4'd6, 1, 64'h50);
    pkt(2, 4'd7, 1, 64'h60);
    pkt(0, 4'd8, 1, 64'h70);
    pkt(1, 4'd9, 1, 64'h80);
    drain();

    // reset after the second beat of a 4-beat packet discards the rest
    pkt(0, 4'hA, 4, 64'hB0, 1);
    wait_acc(0, 2);
    step(1'b1, 1'b1);
    check("midrst_in_tready", bus.in_tready, 3'b000);
    pq[0].delete();
    step();
    check("midrst_out_tvalid", bus.out_tvalid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    pkt(1, 4'hB, 2, 64'hD0);
    drain();

    // granted port 2 goes quiet mid-packet while port 1 waits
    pkt(2, 4'hC, 3, 64'hE0);
    pkt(1, 4'hD, 2, 64'hF0);
    wait_acc(2, 1);
    hold[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("gap_busy", busy, 1'b1);
      check("gap_in_tready1", bus.in_tready[1], 1'b0);
    end
    hold[2] = 1'b0;
    drain();

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
